// File: rtl/mem_read_seq.sv
// Skewed read-address sequencer for the N banks of one systolic operand.
// Walks bank addresses 0..DEPTH-1 num_pass times; bank k sees each beat k cycles after bank 0.
// Optional feature: define MEM_READ_SEQ_PERF_EN to add the stall_cycles counter port.
module mem_read_seq #(
  parameter int unsigned D_W    = 8,
  parameter int unsigned N      = 3,
  parameter int unsigned M      = 6,
  parameter int unsigned PASS_W = 8,
  localparam int unsigned DEPTH = (M * M) / N,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_pass,
  input  logic              stall,
  output logic [AW-1:0]     rd_addr_bram [N-1:0],
  output logic [N-1:0]      rd_en_bram,
  output logic              busy,
`ifdef MEM_READ_SEQ_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N + 1) : 1;

  // Elaboration-time parameter sanity checks.
  if (D_W == 0) begin : g_bad_dw
    $error("D_W must be >= 1");
  end
  if (N == 0 || ((M * M) % N) != 0) begin : g_bad_n
    $error("N must be >= 1 and divide M*M");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] np_q, np_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic              busy_d, done_d;
  logic              issue, last;
  logic [AW-1:0]     cur_addr;
  logic [PASS_W-1:0] cur_pass, cur_np;

  // Next-state: the start cycle itself issues beat 0 so bank 0 fires one cycle after start.
  // Drain spans the bank-0 output cycle plus the N-1 skew stages.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    np_d     = np_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    cur_addr = addr_q;
    cur_pass = pass_q;
    cur_np   = np_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_pass != '0) begin
            issue    = 1'b1;
            cur_addr = '0;
            cur_pass = '0;
            cur_np   = num_pass;
            np_d     = num_pass;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: issue = !stall;
      StDrain: begin
        if (drain_q == CW'(N - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    last = issue && (cur_addr == AW'(DEPTH - 1)) &&
           (({1'b0, cur_pass} + 1'b1) == {1'b0, cur_np});

    if (issue) begin
      if (cur_addr == AW'(DEPTH - 1)) begin
        addr_d = '0;
        pass_d = cur_pass + 1'b1;
      end else begin
        addr_d = cur_addr + 1'b1;
        pass_d = cur_pass;
      end
      state_d = last ? StDrain : StIssue;
      if (last) drain_d = '0;
    end

    busy_d = (state_d != StIdle);
  end

  // Control state and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pass_q  <= '0;
      np_q    <= '0;
      drain_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      np_q    <= np_d;
      drain_q <= drain_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Bank 0 registered issue, then one skew stage per bank; addresses hold on empty slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_bram <= '0;
      for (int k = 0; k < N; k++) rd_addr_bram[k] <= '0;
    end else begin
      rd_en_bram[0] <= issue;
      if (issue) rd_addr_bram[0] <= cur_addr;
      for (int k = 1; k < N; k++) begin
        rd_en_bram[k] <= rd_en_bram[k-1];
        if (rd_en_bram[k-1]) rd_addr_bram[k] <= rd_addr_bram[k-1];
      end
    end
  end

`ifdef MEM_READ_SEQ_PERF_EN
  // Stall counter: cleared on start in idle, saturating count of stalled issue cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (state_q == StIdle && start) begin
      stall_cycles <= '0;
    end else if (state_q == StIssue && stall && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_seq.sv
// Self-checking bench for mem_read_seq: directed scenarios plus random stall runs,
// checked cycle by cycle against a beat-schedule reference model.
module tb_mem_read_seq;

  localparam int unsigned N      = 3;
  localparam int unsigned M      = 6;
  localparam int unsigned PASS_W = 8;
  localparam int unsigned DEPTH  = (M * M) / N;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          MAXC   = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [PASS_W-1:0] num_pass = '0;
  logic              stall = 1'b0;
  logic [AW-1:0]     rd_addr_bram [N-1:0];
  logic [N-1:0]      rd_en_bram;
  logic              busy, done;
`ifdef MEM_READ_SEQ_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  bit stall_v [0:MAXC-1];
  bit b0_en   [0:MAXC-1];
  int b0_addr [0:MAXC-1];

  mem_read_seq #(.D_W(8), .N(N), .M(M), .PASS_W(PASS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_pass     (num_pass),
    .stall        (stall),
    .rd_addr_bram (rd_addr_bram),
    .rd_en_bram   (rd_en_bram),
    .busy         (busy),
`ifdef MEM_READ_SEQ_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int c, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic clear_stalls();
    for (int c = 0; c < MAXC; c++) stall_v[c] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, -1, longint'(rd_en_bram), 0);
    check({tag, "_busy"}, -1, longint'(busy), 0);
    check({tag, "_done"}, -1, longint'(done), 0);
    for (int k = 0; k < N; k++) check({tag, "_addr"}, k, longint'(rd_addr_bram[k]), 0);
  endtask

  // Entered #1 after a posedge with the DUT idle; that clock interval is cycle 0.
  // restart_c >= 0 re-pulses start (with a different num_pass) during the run.
  task automatic run_seq(input int np, input int restart_c);
    int beats, beat, last_out, last_issue, done_c, end_c, exp_stalls;
    logic [N-1:0] exp_en;
    // Reference: list the cycles at which bank 0 delivers each beat.
    for (int c = 0; c < MAXC; c++) begin
      b0_en[c]   = 1'b0;
      b0_addr[c] = 0;
    end
    beats      = np * DEPTH;
    beat       = 0;
    last_out   = 0;
    last_issue = 0;
    for (int c = 0; c < MAXC - 1 && beat < beats; c++) begin
      if (c == 0 || !stall_v[c]) begin
        b0_en[c+1]   = 1'b1;
        b0_addr[c+1] = beat % DEPTH;
        beat++;
        last_out   = c + 1;
        last_issue = c;
      end
    end
    exp_stalls = 0;
    for (int c = 1; c <= last_issue; c++) if (stall_v[c]) exp_stalls++;
    done_c = (np == 0) ? 1 : last_out + N;
    end_c  = done_c + 2;

    start    = 1'b1;
    num_pass = PASS_W'(np);
    stall    = stall_v[0];
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      start    = (c == restart_c);
      num_pass = (c == restart_c) ? PASS_W'(5) : PASS_W'(np);
      stall    = stall_v[c];
      for (int k = 0; k < N; k++) exp_en[k] = (c - k >= 0) ? b0_en[c-k] : 1'b0;
      check("rd_en", c, longint'(rd_en_bram), longint'(exp_en));
      for (int k = 0; k < N; k++)
        if (exp_en[k]) check("rd_addr", c * 16 + k, longint'(rd_addr_bram[k]), b0_addr[c-k]);
      check("busy", c, longint'(busy), (np != 0 && c >= 1 && c <= done_c - 1) ? 1 : 0);
      check("done", c, longint'(done), (c == done_c) ? 1 : 0);
    end
    start = 1'b0;
    stall = 1'b0;
`ifdef MEM_READ_SEQ_PERF_EN
    check("stall_cycles", end_c, longint'(stall_cycles), exp_stalls);
`endif
  endtask

  initial begin
    // Reset state.
    #1;
    check_all_zero("reset");
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single pass, no stall.
    clear_stalls();
    run_seq(1, -1);

    // 2: two passes, contiguous.
    run_seq(2, -1);

    // 3: stall during cycles 4..6.
    clear_stalls();
    stall_v[4] = 1'b1;
    stall_v[5] = 1'b1;
    stall_v[6] = 1'b1;
    run_seq(1, -1);

    // 4: zero passes -> done only.
    clear_stalls();
    run_seq(0, -1);

    // 5: async reset mid-issue, then a clean run.
    start    = 1'b1;
    num_pass = PASS_W'(1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre_reset_busy", 6, longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("after_reset");
    run_seq(1, -1);

    // 6: start re-pulsed while busy is ignored.
    run_seq(1, 5);

    // Random stall patterns and pass counts.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < MAXC; c++) stall_v[c] = ($urandom_range(0, 3) == 0);
      run_seq(int'($urandom_range(1, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
